// File: rtl/fpro_arb_pkg.sv
// Shared types for the FPRO bus arbiter: FSM state encoding and the fixed
// data width of the FPRO MMIO bus.
package fpro_arb_pkg;

  localparam int FPRO_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/fpro_rr_pick.sv
// Combinational round-robin picker: the first pending requester strictly
// after ptr_i (wrapping at N) wins; outputs one-hot grant plus its index.
module fpro_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int j;

  // Walk from lowest to highest priority so the nearest requester overwrites.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = N; k >= 1; k--) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (req_i[j]) begin
        gnt_o    = '0;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpro_bus_arbiter.sv
// Round-robin arbiter sharing the FPRO MMIO slave bus among N_MST masters,
// one registered transaction at a time. Define FPRO_ARB_LOCK_EN for grant locking.
module fpro_bus_arbiter
  import fpro_arb_pkg::*;
#(
  parameter int N_MST    = 2,
  parameter int ADDR_W   = 21,
  parameter int LOCK_MAX = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_MST-1:0]             m_cs,
  input  logic [N_MST-1:0]             m_wr,
  input  logic [N_MST-1:0]             m_rd,
  input  logic [N_MST*ADDR_W-1:0]      m_addr,
  input  logic [N_MST*FPRO_DATA_W-1:0] m_wr_data,
  input  logic [N_MST-1:0]             m_lock,
  output logic [FPRO_DATA_W-1:0]       m_rd_data,
  output logic [N_MST-1:0]             m_ack,
  output logic                         mmio_cs,
  output logic                         mmio_wr,
  output logic                         mmio_rd,
  output logic [ADDR_W-1:0]            mmio_addr,
  output logic [FPRO_DATA_W-1:0]       mmio_wr_data,
  input  logic [FPRO_DATA_W-1:0]       mmio_rd_data
);

  localparam int IW = (N_MST > 1) ? $clog2(N_MST) : 1;
  localparam int CW = $clog2(LOCK_MAX + 1);
`ifdef FPRO_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  arb_state_t             state_q, state_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic [IW-1:0]          gnt_q, gnt_d;
  logic [N_MST-1:0]       ackOh_q, ackOh_d;
  logic [N_MST-1:0]       ack_q, ack_d;
  logic                   cs_q, cs_d, wr_q, wr_d, rd_q, rd_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [FPRO_DATA_W-1:0] wdata_q, wdata_d;
  logic [FPRO_DATA_W-1:0] rdata_q, rdata_d;
  logic                   lock_q, lock_d, hold_q, hold_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic [N_MST-1:0] pend, pickGnt, winOh;
  logic [IW-1:0]    pickIdx, win;
  logic             pickAny, keep;

  assign pend = m_cs & (m_wr | m_rd);

  fpro_rr_pick #(.N(N_MST), .IW(IW)) u_pick (
    .req_i (pend),
    .ptr_i (ptr_q),
    .gnt_o (pickGnt),
    .idx_o (pickIdx),
    .any_o (pickAny)
  );

  // A held lock overrides round-robin only while its owner still requests.
  assign keep  = LOCK_EN && hold_q && pend[gnt_q];
  assign win   = keep ? gnt_q : pickIdx;
  assign winOh = keep ? (N_MST'(1) << gnt_q) : pickGnt;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    ackOh_d = ackOh_q;
    ack_d   = '0;
    cs_d    = cs_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    lock_d  = lock_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (keep || pickAny) begin
          gnt_d   = win;
          ackOh_d = winOh;
          addr_d  = m_addr[int'(win)*ADDR_W +: ADDR_W];
          wdata_d = m_wr_data[int'(win)*FPRO_DATA_W +: FPRO_DATA_W];
          cs_d    = 1'b1;
          wr_d    = m_wr[win];
          rd_d    = m_rd[win] & ~m_wr[win];
          lock_d  = m_lock[win];
          hold_d  = 1'b0;
          cnt_d   = keep ? cnt_q + CW'(1) : CW'(1);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cs_d    = 1'b0;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        rdata_d = rd_q ? mmio_rd_data : '0;
        ack_d   = ackOh_q;
        state_d = ACK;
      end
      ACK: begin
        ptr_d   = gnt_q;
        hold_d  = LOCK_EN && lock_q && (cnt_q < CW'(LOCK_MAX));
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IW'(N_MST - 1);
      gnt_q   <= '0;
      ackOh_q <= '0;
      ack_q   <= '0;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      lock_q  <= 1'b0;
      hold_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      ackOh_q <= ackOh_d;
      ack_q   <= ack_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      lock_q  <= lock_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  assign m_ack        = ack_q;
  assign m_rd_data    = rdata_q;
  assign mmio_cs      = cs_q;
  assign mmio_wr      = wr_q;
  assign mmio_rd      = rd_q;
  assign mmio_addr    = addr_q;
  assign mmio_wr_data = wdata_q;

endmodule

// File: tb/tb_fpro_bus_arbiter.sv
// Bench for fpro_bus_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fpro_bus_arbiter;
  localparam int N        = 2;
  localparam int AW       = 21;
  localparam int LOCK_MAX = 4;
`ifdef FPRO_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  m_cs, m_wr, m_rd, m_lock;
  logic [N*AW-1:0] m_addr;
  logic [N*32-1:0] m_wr_data;
  logic [31:0]   m_rd_data;
  logic [N-1:0]  m_ack;
  logic          mmio_cs, mmio_wr, mmio_rd;
  logic [AW-1:0] mmio_addr;
  logic [31:0]   mmio_wr_data, mmio_rd_data;

  int checks = 0;
  int errors = 0;
  bit cmpEn  = 1'b0;

  always #5 clk = ~clk;

  fpro_bus_arbiter #(.N_MST(N), .ADDR_W(AW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst), .m_cs(m_cs), .m_wr(m_wr), .m_rd(m_rd), .m_addr(m_addr),
    .m_wr_data(m_wr_data), .m_lock(m_lock), .m_rd_data(m_rd_data), .m_ack(m_ack),
    .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd), .mmio_addr(mmio_addr),
    .mmio_wr_data(mmio_wr_data), .mmio_rd_data(mmio_rd_data)
  );

  function automatic logic [31:0] slaveRead(logic [AW-1:0] a);
    if (a == 21'h4) return 32'h1234_5678;
    return {11'h0, a} ^ 32'hC0DE_0000;
  endfunction

  assign mmio_rd_data = slaveRead(mmio_addr);

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a free bus takes the next requester after the
  // last granted one, strobes the slave one cycle later, acks the cycle after.
  int          mPhase, mLast, mW, mCnt;
  bit          mHold, mLockLatched;
  logic        expCs, expWr, expRd;
  logic [AW-1:0] expAddr;
  logic [31:0] expWd, expRdData;
  logic [N-1:0] expAck;

  always @(posedge clk) begin
    logic [N-1:0] pend;
    if (rst) begin
      mPhase = 0; mLast = N - 1; mW = 0; mCnt = 0; mHold = 0; mLockLatched = 0;
      expCs = 0; expWr = 0; expRd = 0; expAddr = '0; expWd = '0;
      expRdData = '0; expAck = '0;
    end else if (mPhase == 0) begin
      pend = m_cs & (m_wr | m_rd);
      if (pend != '0) begin
        int w;
        w = -1;
        if (LOCK_EN && mHold && pend[mLast]) begin
          w = mLast;
          mCnt++;
        end else begin
          for (int k = 1; k <= N; k++)
            if (w < 0 && pend[(mLast + k) % N]) w = (mLast + k) % N;
          mCnt = 1;
        end
        mHold = 0;
        mW = w;
        mLockLatched = m_lock[w];
        expCs   = 1;
        expWr   = m_wr[w];
        expRd   = m_rd[w] && !m_wr[w];
        expAddr = m_addr[w*AW +: AW];
        expWd   = m_wr_data[w*32 +: 32];
        mPhase  = 1;
      end
    end else if (mPhase == 1) begin
      expRdData = expRd ? slaveRead(expAddr) : 32'h0;
      expCs = 0; expWr = 0; expRd = 0;
      expAck = '0;
      expAck[mW] = 1'b1;
      mPhase = 2;
    end else begin
      expAck = '0;
      mLast  = mW;
      mHold  = LOCK_EN && mLockLatched && (mCnt < LOCK_MAX);
      mPhase = 0;
    end
  end

  always @(negedge clk) begin
    if (cmpEn) begin
      checkOutput("mmio_cs", 32'(mmio_cs), 32'(expCs));
      checkOutput("mmio_wr", 32'(mmio_wr), 32'(expWr));
      checkOutput("mmio_rd", 32'(mmio_rd), 32'(expRd));
      checkOutput("mmio_addr", 32'(mmio_addr), 32'(expAddr));
      checkOutput("mmio_wr_data", mmio_wr_data, expWd);
      checkOutput("m_ack", 32'(m_ack), 32'(expAck));
      checkOutput("m_rd_data", m_rd_data, expRdData);
    end
  end

  task automatic applyStimulus(int idx, logic cs, logic wr, logic rd,
                               logic [AW-1:0] addr, logic [31:0] data, logic lock);
    m_cs[idx] = cs; m_wr[idx] = wr; m_rd[idx] = rd; m_lock[idx] = lock;
    m_addr[idx*AW +: AW] = addr;
    m_wr_data[idx*32 +: 32] = data;
  endtask

  task automatic clearAll();
    m_cs = '0; m_wr = '0; m_rd = '0; m_lock = '0; m_addr = '0; m_wr_data = '0;
  endtask

  task automatic doReset();
    @(negedge clk); #1 rst = 1'b1; clearAll();
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst = 1'b0;
  endtask

  logic [N-1:0] ackLog[$];
  int           ackCyc[$];

  task automatic collectAcks(int n, int budget);
    int cyc;
    cyc = 0;
    ackLog.delete(); ackCyc.delete();
    while (ackLog.size() < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (m_ack != '0) begin
        ackLog.push_back(m_ack);
        ackCyc.push_back(cyc);
      end
    end
    if (ackLog.size() < n) checkOutput("ack_timeout", 32'(ackLog.size()), 32'(n));
  endtask

  initial begin
    logic [N-1:0] exp6[5];
    rst = 1'b1;
    clearAll();
    repeat (2) @(posedge clk);
    cmpEn = 1'b1;
    @(negedge clk);
    checkOutput("reset_ack", 32'(m_ack), 32'h0);
    checkOutput("reset_cs", 32'(mmio_cs), 32'h0);
    #1 rst = 1'b0;

    // single write from m0
    @(negedge clk); #1 applyStimulus(0, 1, 1, 0, 21'h00010, 32'hDEADBEEF, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("t1_wr", 32'(mmio_wr), 32'h1);
    checkOutput("t1_addr", 32'(mmio_addr), 32'h10);
    checkOutput("t1_data", mmio_wr_data, 32'hDEADBEEF);
    @(negedge clk);
    checkOutput("t1_ack", 32'(m_ack), 32'h1);
    #1 clearAll();
    repeat (2) @(negedge clk);

    // single read from m1
    #1 applyStimulus(1, 1, 0, 1, 21'h00004, 32'h0, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("t2_rd", 32'(mmio_rd), 32'h1);
    @(negedge clk);
    checkOutput("t2_ack", 32'(m_ack), 32'h2);
    checkOutput("t2_rdata", m_rd_data, 32'h1234_5678);
    #1 clearAll();
    repeat (2) @(negedge clk);

    // wr and rd together execute as a write
    #1 applyStimulus(0, 1, 1, 1, 21'h00004, 32'h0000_0055, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("t5_wr", 32'(mmio_wr), 32'h1);
    checkOutput("t5_rd", 32'(mmio_rd), 32'h0);
    @(negedge clk);
    checkOutput("t5_ack", 32'(m_ack), 32'h1);
    checkOutput("t5_rdata", m_rd_data, 32'h0);
    #1 clearAll();

    // continuous requests from reset alternate, one ack per 3 cycles
    doReset();
    applyStimulus(0, 1, 1, 0, 21'h00100, 32'h1111_0001, 0);
    applyStimulus(1, 1, 0, 1, 21'h00020, 32'h0, 0);
    collectAcks(4, 30);
    if (ackLog.size() == 4) begin
      checkOutput("t3_g0", 32'(ackLog[0]), 32'h1);
      checkOutput("t3_g1", 32'(ackLog[1]), 32'h2);
      checkOutput("t3_g2", 32'(ackLog[2]), 32'h1);
      checkOutput("t3_g3", 32'(ackLog[3]), 32'h2);
      checkOutput("t3_gap", 32'(ackCyc[3] - ackCyc[0]), 32'd9);
    end
    #1 clearAll();
    repeat (3) @(negedge clk);

    // reset during ISSUE aborts, m0 gets the next grant
    doReset();
    applyStimulus(0, 1, 1, 0, 21'h00040, 32'hA0A0_0000, 0);
    applyStimulus(1, 1, 1, 0, 21'h00044, 32'hB0B0_0000, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("t4_issue_cs", 32'(mmio_cs), 32'h1);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("t4_abort_cs", 32'(mmio_cs), 32'h0);
    checkOutput("t4_abort_ack", 32'(m_ack), 32'h0);
    #1 rst = 1'b0;
    collectAcks(1, 10);
    if (ackLog.size() == 1) checkOutput("t4_next", 32'(ackLog[0]), 32'h1);
    #1 clearAll();
    repeat (3) @(negedge clk);

    // m0 locked with m1 pending
    doReset();
    applyStimulus(0, 1, 1, 0, 21'h00080, 32'h0000_0080, 1);
    applyStimulus(1, 1, 1, 0, 21'h00084, 32'h0000_0084, 0);
    if (LOCK_EN) exp6 = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    else         exp6 = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    collectAcks(5, 40);
    if (ackLog.size() == 5)
      for (int i = 0; i < 5; i++) checkOutput($sformatf("t6_g%0d", i), 32'(ackLog[i]), 32'(exp6[i]));
    #1 clearAll();
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
